alarm_set: RTL

ALARM_SET -- requirements
Module: alarm_set

---
 rtl/alarm_set_if.sv | 49 ++++
 rtl/alarm_set.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alarm_set_if.sv
// ---------------------------------------------------------------------------
// alarm_set_if
// Groups the alarm-set block's user inputs, time-of-day inputs and alarm
// outputs into one bundle.
//   master : drives buttons, mode select, second tick and current time;
//            observes stored alarm time and status.
//   slave  : the alarm_set block itself.
// Signals:
//   MODE_EN                               alarm-set mode selected
//   BTN_HOUR, BTN_MIN, BTN_ARM, BTN_STOP  debounced button levels
//   SEC_TICK                              one-cycle pulse per second
//   T_H10..T_S1                           current time, BCD
//   A_H10..A_M1                           stored alarm time, BCD
//   FND_EN                                display enable (delayed MODE_EN)
//   ARMED, ALARM_RING                     status
// ---------------------------------------------------------------------------
interface alarm_set_if;
  logic       MODE_EN;
  logic       BTN_HOUR;
  logic       BTN_MIN;
  logic       BTN_ARM;
  logic       BTN_STOP;
  logic       SEC_TICK;
  logic [3:0] T_H10;
  logic [3:0] T_H1;
  logic [3:0] T_M10;
  logic [3:0] T_M1;
  logic [3:0] T_S10;
  logic [3:0] T_S1;
  logic [3:0] A_H10;
  logic [3:0] A_H1;
  logic [3:0] A_M10;
  logic [3:0] A_M1;
  logic       FND_EN;
  logic       ARMED;
  logic       ALARM_RING;

  modport master (
    output MODE_EN, BTN_HOUR, BTN_MIN, BTN_ARM, BTN_STOP, SEC_TICK,
    output T_H10, T_H1, T_M10, T_M1, T_S10, T_S1,
    input  A_H10, A_H1, A_M10, A_M1, FND_EN, ARMED, ALARM_RING
  );

  modport slave (
    input  MODE_EN, BTN_HOUR, BTN_MIN, BTN_ARM, BTN_STOP, SEC_TICK,
    input  T_H10, T_H1, T_M10, T_M1, T_S10, T_S1,
    output A_H10, A_H1, A_M10, A_M1, FND_EN, ARMED, ALARM_RING
  );
endinterface

// File: rtl/alarm_set.sv
// ---------------------------------------------------------------------------
// alarm_set
// Stores an HH:MM alarm time edited by button presses, compares it with the
// current time and rings for RING_SECS seconds or until stopped.
// Ports:
//   CLK     system clock, rising edge
//   RESETN  asynchronous active-low reset
//   bus     alarm_set_if.slave (buttons, time in, alarm time/status out)
// Parameters:
//   RING_SECS  number of SEC_TICK pulses the alarm rings before auto-stop
// ---------------------------------------------------------------------------
module alarm_set #(
  parameter int RING_SECS = 60
) (
  input  logic        CLK,
  input  logic        RESETN,
  alarm_set_if.slave  bus
);

  localparam int CW = (RING_SECS < 1) ? 1 : $clog2(RING_SECS + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(RING_SECS);
  localparam logic [CW-1:0] CNT_LAST = CW'(RING_SECS - 1);

  typedef enum logic [1:0] {
    S_DISARMED = 2'd0,
    S_ARMED    = 2'd1,
    S_RINGING  = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          lock_reg, lock_next;
  logic [3:0]    ah10_reg, ah1_reg, am10_reg, am1_reg;
  logic [3:0]    ah10_next, ah1_next, am10_next, am1_next;
  logic          fnd_en_reg;

  // Button edge detection: bit 0 hour, 1 minute, 2 arm, 3 stop.
  logic [3:0] btn_now;
  logic [3:0] btn_prev_reg;
  logic [3:0] btn_rise;

  assign btn_now = {bus.BTN_STOP, bus.BTN_ARM, bus.BTN_MIN, bus.BTN_HOUR};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_edge
      always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) btn_prev_reg[gi] <= 1'b0;
        else         btn_prev_reg[gi] <= btn_now[gi];
      end
      assign btn_rise[gi] = btn_now[gi] & ~btn_prev_reg[gi];
    end
  endgenerate

  logic match;
  logic edit_ok;
  logic arm_ev;
  logic stop_ev;

  assign match = (bus.T_H10 == ah10_reg) && (bus.T_H1 == ah1_reg) &&
                 (bus.T_M10 == am10_reg) && (bus.T_M1 == am1_reg) &&
                 (bus.T_S10 == 4'd0) && (bus.T_S1 == 4'd0);
  assign edit_ok = bus.MODE_EN && (state_reg != S_RINGING);
  assign arm_ev  = btn_rise[2] && bus.MODE_EN;
  assign stop_ev = btn_rise[3];

  // Alarm time editing. Hour and minute are independent counters, so a
  // minute wrap never carries into the hour.
  always_comb begin
    ah10_next = ah10_reg;
    ah1_next  = ah1_reg;
    am10_next = am10_reg;
    am1_next  = am1_reg;
    if (edit_ok && btn_rise[0]) begin
      if (ah10_reg == 4'd2 && ah1_reg == 4'd3) begin
        ah10_next = 4'd0;
        ah1_next  = 4'd0;
      end else if (ah1_reg == 4'd9) begin
        ah10_next = ah10_reg + 4'd1;
        ah1_next  = 4'd0;
      end else begin
        ah1_next  = ah1_reg + 4'd1;
      end
    end
    if (edit_ok && btn_rise[1]) begin
      if (am10_reg == 4'd5 && am1_reg == 4'd9) begin
        am10_next = 4'd0;
        am1_next  = 4'd0;
      end else if (am1_reg == 4'd9) begin
        am10_next = am10_reg + 4'd1;
        am1_next  = 4'd0;
      end else begin
        am1_next  = am1_reg + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ah10_reg   <= 4'd0;
      ah1_reg    <= 4'd0;
      am10_reg   <= 4'd0;
      am1_reg    <= 4'd0;
      fnd_en_reg <= 1'b0;
    end else begin
      ah10_reg   <= ah10_next;
      ah1_reg    <= ah1_next;
      am10_reg   <= am10_next;
      am1_reg    <= am1_next;
      fnd_en_reg <= bus.MODE_EN;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg <= S_DISARMED;
      cnt_reg   <= '0;
      lock_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      lock_reg  <= lock_next;
    end
  end

  // Next-state logic. The match lock keeps a stopped or timed-out alarm from
  // re-ringing within the same matching second; it releases as soon as the
  // time no longer matches.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_next  = lock_reg;
    if (!match) lock_next = 1'b0;
    case (state_reg)
      S_DISARMED: begin
        if (arm_ev) state_next = S_ARMED;
      end
      S_ARMED: begin
        if (arm_ev) begin
          state_next = S_DISARMED;
        end else if (match && !lock_reg) begin
          state_next = S_RINGING;
          cnt_next   = '0;
          lock_next  = 1'b1;
        end
      end
      S_RINGING: begin
        if (bus.SEC_TICK && cnt_reg != CNT_MAX) cnt_next = cnt_reg + CW'(1);
        if (arm_ev) begin
          state_next = S_DISARMED;
        end else if (stop_ev) begin
          state_next = S_ARMED;
        end else if (bus.SEC_TICK && cnt_reg >= CNT_LAST) begin
          state_next = S_ARMED;
        end
      end
      default: state_next = S_DISARMED;
    endcase
  end

  // Status is decoded straight from the state register so reset drops it
  // without waiting for a clock edge.
  assign bus.ARMED      = (state_reg != S_DISARMED);
  assign bus.ALARM_RING = (state_reg == S_RINGING);
  assign bus.FND_EN     = fnd_en_reg;
  assign bus.A_H10      = ah10_reg;
  assign bus.A_H1       = ah1_reg;
  assign bus.A_M10      = am10_reg;
  assign bus.A_M1       = am1_reg;

endmodule
